// File: rtl/sobel_frame_sequencer.sv
// Walks the interior pixels of a ROWS x COLS image, fetches each 3x3 neighbourhood,
// runs the Sobel core and writes the results. Optional watchdog: SOBEL_SEQ_WATCHDOG_EN.
module sobel_frame_sequencer #(
    parameter int ROWS    = 147,
    parameter int COLS    = 144,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    output logic              frame_busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] src_addr,
    output logic              src_rd,
    input  logic [7:0]        src_data,
    output logic [7:0]        pixel_1_bin,
    output logic [7:0]        pixel_2_bin,
    output logic [7:0]        pixel_3_bin,
    output logic [7:0]        pixel_4_bin,
    output logic [7:0]        pixel_6_bin,
    output logic [7:0]        pixel_7_bin,
    output logic [7:0]        pixel_8_bin,
    output logic [7:0]        pixel_9_bin,
    output logic              core_start,
    input  logic              core_done,
    input  logic [7:0]        core_z,
    output logic [ADDR_W-1:0] edge_addr,
    output logic              edge_we,
    output logic [7:0]        edge_data,
    output logic              timeout_err,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_WRITE, S_ADVANCE, S_FIN
    } state_t;

    localparam bit                L_SMALL  = (ROWS < 3) || (COLS < 3);
    localparam logic [ADDR_W-1:0] L_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] L_COLS   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] L_EDGE_W = ADDR_W'((COLS > 2) ? COLS - 2 : 1);
    localparam logic [ADDR_W-1:0] L_I_LAST = ADDR_W'((ROWS > 2) ? ROWS - 2 : 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_j;
    logic [3:0]        r_fcnt;
    logic [7:0][7:0]   r_pix;
    logic              r_done_q;
    logic [7:0]        r_z;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [2:0]        w_cap;
    logic              w_done_edge;
    logic              w_timeout;

    assign w_done_edge = core_done && !r_done_q;
    // Read slot k lands one cycle later, so slot fcnt-1 is captured (wraps 8 -> 7).
    assign w_cap       = r_fcnt[2:0] - 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (frame_start) w_next = L_SMALL ? S_FIN : S_FETCH;
            S_FETCH:   if (r_fcnt == 4'd8) w_next = S_LAUNCH;
            S_LAUNCH:  w_next = S_WAIT;
            S_WAIT:    if (w_done_edge || w_timeout) w_next = S_WRITE;
            S_WRITE:   w_next = S_ADVANCE;
            S_ADVANCE: w_next = (r_j == L_EDGE_W && r_i == L_I_LAST) ? S_FIN : S_FETCH;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Neighbour order p1,p2,p3,p4,p6,p7,p8,p9; the centre is never fetched.
    always_comb begin
        w_row = r_i;
        w_col = r_j;
        case (r_fcnt)
            4'd0:    begin w_row = r_i - L_ONE; w_col = r_j - L_ONE; end
            4'd1:    begin w_row = r_i - L_ONE; w_col = r_j;         end
            4'd2:    begin w_row = r_i - L_ONE; w_col = r_j + L_ONE; end
            4'd3:    begin w_row = r_i;         w_col = r_j - L_ONE; end
            4'd4:    begin w_row = r_i;         w_col = r_j + L_ONE; end
            4'd5:    begin w_row = r_i + L_ONE; w_col = r_j - L_ONE; end
            4'd6:    begin w_row = r_i + L_ONE; w_col = r_j;         end
            4'd7:    begin w_row = r_i + L_ONE; w_col = r_j + L_ONE; end
            default: begin w_row = r_i;         w_col = r_j;         end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i      <= L_ONE;
            r_j      <= L_ONE;
            r_fcnt   <= 4'd0;
            r_pix    <= '0;
            r_done_q <= 1'b0;
            r_z      <= 8'h00;
        end else begin
            r_done_q <= core_done;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_i <= L_ONE;
                        r_j <= L_ONE;
                    end
                end
                S_FETCH: begin
                    r_fcnt <= (r_fcnt == 4'd8) ? 4'd0 : r_fcnt + 4'd1;
                    if (r_fcnt != 4'd0) r_pix[w_cap] <= src_data;
                end
                S_WAIT: begin
                    if (w_done_edge)    r_z <= core_z;
                    else if (w_timeout) r_z <= 8'h00;
                end
                S_ADVANCE: begin
                    if (r_j == L_EDGE_W) begin
                        r_j <= L_ONE;
                        r_i <= r_i + L_ONE;
                    end else begin
                        r_j <= r_j + L_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SOBEL_SEQ_WATCHDOG_EN
    localparam int L_WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [L_WC_W-1:0] r_wcnt;
    logic              r_terr;

    assign w_timeout = (r_state == S_WAIT) && !w_done_edge && (r_wcnt == L_WC_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wcnt <= '0;
            r_terr <= 1'b0;
        end else begin
            if (r_state == S_WAIT) r_wcnt <= r_wcnt + L_WC_W'(1);
            else                   r_wcnt <= '0;
            if (r_state == S_IDLE && frame_start) r_terr <= 1'b0;
            else if (w_timeout)                   r_terr <= 1'b1;
        end
    end

    assign timeout_err = r_terr;
`else
    // Always false; WAIT has no time limit without the watchdog.
    assign w_timeout   = (TIMEOUT < 0);
    assign timeout_err = 1'b0;
`endif

    assign frame_busy  = (r_state != S_IDLE);
    assign frame_done  = (r_state == S_FIN);
    assign src_rd      = (r_state == S_FETCH) && !r_fcnt[3];
    assign src_addr    = src_rd ? (w_row * L_COLS + w_col) : '0;
    assign core_start  = !((r_state == S_LAUNCH) || (r_state == S_WAIT));
    assign edge_we     = (r_state == S_WRITE);
    assign edge_addr   = (r_i - L_ONE) * L_EDGE_W + (r_j - L_ONE);
    assign edge_data   = r_z;
    assign dbg_state   = r_state;

    assign pixel_1_bin = r_pix[0];
    assign pixel_2_bin = r_pix[1];
    assign pixel_3_bin = r_pix[2];
    assign pixel_4_bin = r_pix[3];
    assign pixel_6_bin = r_pix[4];
    assign pixel_7_bin = r_pix[5];
    assign pixel_8_bin = r_pix[6];
    assign pixel_9_bin = r_pix[7];

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer: three geometries (3x3, 4x5, 2x5) with behavioural core models.
module tb_sobel_frame_sequencer;
    localparam int AW = 16;
    localparam int DR[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    localparam int DC[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- instance A: 3x3, TIMEOUT=16 ----------------
    logic fs_a = 1'b0, busy_a, done_a, rd_a, cs_a, we_a, terr_a;
    logic [AW-1:0] saddr_a, eaddr_a;
    logic [7:0] sdata_a = 8'h00, edata_a, z_a = 8'hAB;
    logic [7:0] p1_a, p2_a, p3_a, p4_a, p6_a, p7_a, p8_a, p9_a;
    logic [2:0] st_a;
    logic cd_a, cd_mdl_a = 1'b0, mute_a = 1'b0, force_a = 1'b0, force_val_a = 1'b0;
    int cnt_a = 0;
    assign cd_a = force_a ? force_val_a : cd_mdl_a;

    sobel_frame_sequencer #(.ROWS(3), .COLS(3), .ADDR_W(AW), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset_n), .frame_start(fs_a), .frame_busy(busy_a), .frame_done(done_a),
        .src_addr(saddr_a), .src_rd(rd_a), .src_data(sdata_a),
        .pixel_1_bin(p1_a), .pixel_2_bin(p2_a), .pixel_3_bin(p3_a), .pixel_4_bin(p4_a),
        .pixel_6_bin(p6_a), .pixel_7_bin(p7_a), .pixel_8_bin(p8_a), .pixel_9_bin(p9_a),
        .core_start(cs_a), .core_done(cd_a), .core_z(z_a), .edge_addr(eaddr_a), .edge_we(we_a),
        .edge_data(edata_a), .timeout_err(terr_a), .dbg_state(st_a));

    // ---------------- instance B: 4x5 ----------------
    logic fs_b = 1'b0, busy_b, done_b, rd_b, cs_b, we_b, terr_b, cd_b = 1'b0;
    logic [AW-1:0] saddr_b, eaddr_b;
    logic [7:0] sdata_b = 8'h00, edata_b, z_b = 8'h00;
    logic [7:0] p1_b, p2_b, p3_b, p4_b, p6_b, p7_b, p8_b, p9_b;
    logic [2:0] st_b;
    int cnt_b = 0, d_b = 1;

    sobel_frame_sequencer #(.ROWS(4), .COLS(5), .ADDR_W(AW)) dut_b (
        .clk(clk), .reset(reset_n), .frame_start(fs_b), .frame_busy(busy_b), .frame_done(done_b),
        .src_addr(saddr_b), .src_rd(rd_b), .src_data(sdata_b),
        .pixel_1_bin(p1_b), .pixel_2_bin(p2_b), .pixel_3_bin(p3_b), .pixel_4_bin(p4_b),
        .pixel_6_bin(p6_b), .pixel_7_bin(p7_b), .pixel_8_bin(p8_b), .pixel_9_bin(p9_b),
        .core_start(cs_b), .core_done(cd_b), .core_z(z_b), .edge_addr(eaddr_b), .edge_we(we_b),
        .edge_data(edata_b), .timeout_err(terr_b), .dbg_state(st_b));

    // ---------------- instance C: 2x5 (degenerate) ----------------
    logic fs_c = 1'b0, busy_c, done_c, rd_c, cs_c, we_c, terr_c;
    logic [AW-1:0] saddr_c, eaddr_c;
    logic [7:0] edata_c, p1_c, p2_c, p3_c, p4_c, p6_c, p7_c, p8_c, p9_c;
    logic [2:0] st_c;

    sobel_frame_sequencer #(.ROWS(2), .COLS(5), .ADDR_W(AW)) dut_c (
        .clk(clk), .reset(reset_n), .frame_start(fs_c), .frame_busy(busy_c), .frame_done(done_c),
        .src_addr(saddr_c), .src_rd(rd_c), .src_data(8'h00),
        .pixel_1_bin(p1_c), .pixel_2_bin(p2_c), .pixel_3_bin(p3_c), .pixel_4_bin(p4_c),
        .pixel_6_bin(p6_c), .pixel_7_bin(p7_c), .pixel_8_bin(p8_c), .pixel_9_bin(p9_c),
        .core_start(cs_c), .core_done(1'b0), .core_z(8'h00), .edge_addr(eaddr_c), .edge_we(we_c),
        .edge_data(edata_c), .timeout_err(terr_c), .dbg_state(st_c));

    // ---------------- models ----------------
    function automatic logic [7:0] src_val(input logic [AW-1:0] a);
        return a[7:0];
    endfunction

    function automatic logic [7:0] z_fn(input logic [7:0] q1, q2, q3, q4, q6, q7, q8, q9);
        return (q1 + 8'd3 * q3 + 8'd5 * q7 + 8'd7 * q9) ^ (q2 + q4 + q6 + q8);
    endfunction

    always @(posedge clk) begin
        if (rd_a) sdata_a <= src_val(saddr_a);
        if (rd_b) sdata_b <= src_val(saddr_b);
    end

    // Core A: raises done 5 cycles after it first sees core_start low, result 8'hAB.
    always @(posedge clk) begin
        if (!cs_a && !mute_a) begin
            cnt_a <= cnt_a + 1;
            if (cnt_a == 5) cd_mdl_a <= 1'b1;
        end else begin
            cnt_a <= 0;
            cd_mdl_a <= 1'b0;
        end
    end

    // Core B: random latency, result is a function of the presented window.
    always @(posedge clk) begin
        if (!cs_b) begin
            cnt_b <= cnt_b + 1;
            if (cnt_b == d_b) begin
                cd_b <= 1'b1;
                z_b  <= z_fn(p1_b, p2_b, p3_b, p4_b, p6_b, p7_b, p8_b, p9_b);
            end
        end else begin
            cnt_b <= 0;
            cd_b  <= 1'b0;
            d_b   <= $urandom_range(1, 6);
        end
    end

    // ---------------- scoreboard ----------------
    logic [AW-1:0]   rd_q_a[$], rd_q_b[$];
    logic [AW+7:0]   wr_q_a[$], wr_q_b[$];
    int wr_cnt_a = 0, wr_cnt_b = 0, done_cnt_b = 0, act_cnt_c = 0;

    always @(negedge clk) begin
        logic [AW-1:0] ea;
        logic [AW+7:0] ew;
        if (rd_a) begin
            checks++;
            if (rd_q_a.size() == 0) begin
                failures++; $display("FAIL rd_a unexpected read got=%0d", saddr_a);
            end else begin
                ea = rd_q_a.pop_front();
                if (saddr_a !== ea) begin
                    failures++; $display("FAIL rd_a addr got=%0d exp=%0d", saddr_a, ea);
                end
            end
        end
        if (we_a) begin
            wr_cnt_a++;
            checks++;
            if (wr_q_a.size() == 0) begin
                failures++; $display("FAIL wr_a unexpected write got=%0d/%02h", eaddr_a, edata_a);
            end else begin
                ew = wr_q_a.pop_front();
                if ({eaddr_a, edata_a} !== ew) begin
                    failures++; $display("FAIL wr_a got=%0d/%02h exp=%0d/%02h", eaddr_a, edata_a, ew[AW+7:8], ew[7:0]);
                end
            end
        end
        if (rd_b) begin
            checks++;
            if (rd_q_b.size() == 0) begin
                failures++; $display("FAIL rd_b unexpected read got=%0d", saddr_b);
            end else begin
                ea = rd_q_b.pop_front();
                if (saddr_b !== ea) begin
                    failures++; $display("FAIL rd_b addr got=%0d exp=%0d", saddr_b, ea);
                end
            end
        end
        if (we_b) begin
            wr_cnt_b++;
            checks++;
            if (wr_q_b.size() == 0) begin
                failures++; $display("FAIL wr_b unexpected write got=%0d/%02h", eaddr_b, edata_b);
            end else begin
                ew = wr_q_b.pop_front();
                if ({eaddr_b, edata_b} !== ew) begin
                    failures++; $display("FAIL wr_b got=%0d/%02h exp=%0d/%02h", eaddr_b, edata_b, ew[AW+7:8], ew[7:0]);
                end
            end
        end
        if (done_b) done_cnt_b++;
        if (rd_c || we_c) act_cnt_c++;
    end

    // ---------------- helpers (waiting only) ----------------
    function automatic logic [2:0] state_of(input int w);
        return (w == 0) ? st_a : st_b;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 0) ? done_a : done_b;
    endfunction

    task automatic wait_state(input int w, input logic [2:0] st, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (state_of(w) == st) ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int w, input int budget, output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done_of(w)) ok = 1'b1;
        end
    endtask

    task automatic push_a(input logic [7:0] z);
        for (int k = 0; k < 8; k++) rd_q_a.push_back(AW'((1 + DR[k]) * 3 + (1 + DC[k])));
        wr_q_a.push_back({AW'(0), z});
    endtask

    task automatic push_b(input int n_rd, input int n_wr);
        int p, a;
        logic [7:0] v[8];
        p = 0;
        for (int i = 1; i <= 2; i++) begin
            for (int j = 1; j <= 3; j++) begin
                for (int k = 0; k < 8; k++) begin
                    a = (i + DR[k]) * 5 + (j + DC[k]);
                    v[k] = src_val(AW'(a));
                    if (p < n_rd) rd_q_b.push_back(AW'(a));
                end
                if (p < n_wr) wr_q_b.push_back({AW'((i - 1) * 3 + (j - 1)), z_fn(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7])});
                p++;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_a, done_a, rd_a, cs_a, we_a, terr_a} !== 6'b000100) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000100", {busy_a, done_a, rd_a, cs_a, we_a, terr_a});
        end
        checks++;
        if ({saddr_a, eaddr_a, edata_a} !== '0) begin
            failures++; $display("FAIL reset_addr got=%0d/%0d/%02h exp=0/0/00", saddr_a, eaddr_a, edata_a);
        end
        checks++;
        if ({p1_a, p2_a, p3_a, p4_a, p6_a, p7_a, p8_a, p9_a} !== 64'd0) begin
            failures++; $display("FAIL reset_pix got=%016h exp=0", {p1_a, p2_a, p3_a, p4_a, p6_a, p7_a, p8_a, p9_a});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_small_frame();
        int cyc;
        bit ok;
        push_a(8'hAB);
        fs_a = 1'b1;
        @(negedge clk);
        fs_a = 1'b0;
        checks++;
        if ({busy_a, rd_a} !== 2'b11) begin
            failures++; $display("FAIL small_first_cycle busy/rd got=%b exp=11", {busy_a, rd_a});
        end
        wait_done(0, 200, cyc, ok);
        checks++;
        if (!ok || cyc != 18) begin
            failures++; $display("FAIL small_done_latency got=%0d ok=%0d exp=18", cyc, ok);
        end
        @(negedge clk);
        checks++;
        if ({done_a, busy_a} !== 2'b00) begin
            failures++; $display("FAIL small_done_pulse done/busy got=%b exp=00", {done_a, busy_a});
        end
        checks++;
        if (rd_q_a.size() != 0 || wr_q_a.size() != 0) begin
            failures++; $display("FAIL small_queues left rd=%0d wr=%0d exp=0/0", rd_q_a.size(), wr_q_a.size());
        end
    endtask

    task automatic test_raster();
        int cyc, w0, d0;
        bit ok;
        w0 = wr_cnt_b;
        d0 = done_cnt_b;
        push_b(6, 6);
        fs_b = 1'b1;
        @(negedge clk);
        fs_b = 1'b0;
        wait_done(1, 2000, cyc, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL raster_done got=timeout exp=frame_done");
        end
        @(negedge clk);
        checks++;
        if (wr_cnt_b - w0 != 6 || done_cnt_b - d0 != 1) begin
            failures++; $display("FAIL raster_counts writes=%0d dones=%0d exp=6/1", wr_cnt_b - w0, done_cnt_b - d0);
        end
        checks++;
        if (rd_q_b.size() != 0 || wr_q_b.size() != 0) begin
            failures++; $display("FAIL raster_queues left rd=%0d wr=%0d exp=0/0", rd_q_b.size(), wr_q_b.size());
        end
    endtask

    task automatic test_start_ignored();
        int cyc, w0, d0;
        bit ok;
        w0 = wr_cnt_b;
        d0 = done_cnt_b;
        push_b(6, 6);
        fs_b = 1'b1;
        @(negedge clk);
        fs_b = 1'b0;
        wait_state(1, 3'd3, 100, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL ignored_reach_wait got=timeout exp=WAIT");
        end
        fs_b = 1'b1;
        @(negedge clk);
        fs_b = 1'b0;
        wait_done(1, 2000, cyc, ok);
        repeat (40) @(negedge clk);
        checks++;
        if (!ok || wr_cnt_b - w0 != 6 || done_cnt_b - d0 != 1 || busy_b !== 1'b0) begin
            failures++; $display("FAIL ignored_start writes=%0d dones=%0d busy=%b exp=6/1/0", wr_cnt_b - w0, done_cnt_b - d0, busy_b);
        end
        checks++;
        if (rd_q_b.size() != 0 || wr_q_b.size() != 0) begin
            failures++; $display("FAIL ignored_queues left rd=%0d wr=%0d exp=0/0", rd_q_b.size(), wr_q_b.size());
        end
    endtask

    task automatic test_degenerate();
        fs_c = 1'b1;
        @(negedge clk);
        fs_c = 1'b0;
        checks++;
        if ({done_c, busy_c} !== 2'b11) begin
            failures++; $display("FAIL degen_fin done/busy got=%b exp=11", {done_c, busy_c});
        end
        @(negedge clk);
        checks++;
        if ({done_c, busy_c} !== 2'b00) begin
            failures++; $display("FAIL degen_idle done/busy got=%b exp=00", {done_c, busy_c});
        end
        repeat (20) @(negedge clk);
        checks++;
        if (act_cnt_c != 0) begin
            failures++; $display("FAIL degen_activity got=%0d exp=0", act_cnt_c);
        end
    endtask

    task automatic test_level_ignored();
        int cyc, w0;
        bit ok;
        w0 = wr_cnt_a;
        force_a = 1'b1;
        force_val_a = 1'b1;
        push_a(8'hAB);
        fs_a = 1'b1;
        @(negedge clk);
        fs_a = 1'b0;
        wait_state(0, 3'd3, 100, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || st_a !== 3'd3 || wr_cnt_a != w0) begin
            failures++; $display("FAIL level_not_edge state=%0d writes=%0d exp=3/0", st_a, wr_cnt_a - w0);
        end
        force_val_a = 1'b0;
        @(negedge clk);
        force_val_a = 1'b1;
        wait_done(0, 50, cyc, ok);
        force_a = 1'b0;
        @(negedge clk);
        checks++;
        if (!ok || wr_cnt_a - w0 != 1 || wr_q_a.size() != 0) begin
            failures++; $display("FAIL level_edge_write writes=%0d ok=%0d exp=1/1", wr_cnt_a - w0, ok);
        end
    endtask

    task automatic test_timeout();
        int cyc, w0;
        bit ok;
        w0 = wr_cnt_a;
        mute_a = 1'b1;
`ifdef SOBEL_SEQ_WATCHDOG_EN
        push_a(8'h00);
`else
        for (int k = 0; k < 8; k++) rd_q_a.push_back(AW'((1 + DR[k]) * 3 + (1 + DC[k])));
`endif
        fs_a = 1'b1;
        @(negedge clk);
        fs_a = 1'b0;
        wait_state(0, 3'd2, 100, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL timeout_reach_launch got=timeout exp=LAUNCH");
        end
`ifdef SOBEL_SEQ_WATCHDOG_EN
        cyc = 0;
        while (!we_a && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 17) begin
            failures++; $display("FAIL timeout_write_latency got=%0d exp=17", cyc);
        end
        @(negedge clk);
        checks++;
        if (terr_a !== 1'b1) begin
            failures++; $display("FAIL timeout_err_set got=%b exp=1", terr_a);
        end
        wait_done(0, 20, cyc, ok);
        checks++;
        if (!ok || wr_cnt_a - w0 != 1) begin
            failures++; $display("FAIL timeout_frame_end ok=%0d writes=%0d exp=1/1", ok, wr_cnt_a - w0);
        end
        mute_a = 1'b0;
        @(negedge clk);
        push_a(8'hAB);
        fs_a = 1'b1;
        @(negedge clk);
        fs_a = 1'b0;
        checks++;
        if (terr_a !== 1'b0) begin
            failures++; $display("FAIL timeout_err_clear got=%b exp=0", terr_a);
        end
        wait_done(0, 200, cyc, ok);
        @(negedge clk);
        checks++;
        if (!ok || wr_q_a.size() != 0) begin
            failures++; $display("FAIL timeout_next_frame ok=%0d left=%0d exp=1/0", ok, wr_q_a.size());
        end
`else
        repeat (100) @(negedge clk);
        checks++;
        if (st_a !== 3'd3 || terr_a !== 1'b0 || wr_cnt_a != w0) begin
            failures++; $display("FAIL nowd_stays_wait state=%0d terr=%b writes=%0d exp=3/0/0", st_a, terr_a, wr_cnt_a - w0);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mute_a = 1'b0;
        @(negedge clk);
        checks++;
        if (st_a !== 3'd0 || rd_q_a.size() != 0) begin
            failures++; $display("FAIL nowd_recover state=%0d left=%0d exp=0/0", st_a, rd_q_a.size());
        end
`endif
    endtask

    task automatic test_reset_mid();
        int waits, d0, w0;
        logic [2:0] prev;
        d0 = done_cnt_b;
        w0 = wr_cnt_b;
        push_b(3, 2);
        fs_b = 1'b1;
        @(negedge clk);
        fs_b = 1'b0;
        waits = 0;
        prev = st_b;
        for (int n = 0; n < 500 && waits < 3; n++) begin
            @(negedge clk);
            if (st_b == 3'd3 && prev != 3'd3) waits++;
            prev = st_b;
        end
        checks++;
        if (waits != 3) begin
            failures++; $display("FAIL mid_reach_wait3 got=%0d exp=3", waits);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy_b, done_b, rd_b, cs_b, we_b, terr_b} !== 6'b000100) begin
            failures++; $display("FAIL mid_reset_ctrl got=%b exp=000100", {busy_b, done_b, rd_b, cs_b, we_b, terr_b});
        end
        checks++;
        if ({saddr_b, eaddr_b, edata_b, p1_b, p2_b, p3_b, p4_b, p6_b, p7_b, p8_b, p9_b} !== '0) begin
            failures++; $display("FAIL mid_reset_data got=%0d/%0d/%02h exp=0/0/00", saddr_b, eaddr_b, edata_b);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (done_cnt_b != d0 || wr_cnt_b - w0 != 2 || busy_b !== 1'b0) begin
            failures++; $display("FAIL mid_abort dones=%0d writes=%0d busy=%b exp=0/2/0", done_cnt_b - d0, wr_cnt_b - w0, busy_b);
        end
        checks++;
        if (rd_q_b.size() != 0 || wr_q_b.size() != 0) begin
            failures++; $display("FAIL mid_queues left rd=%0d wr=%0d exp=0/0", rd_q_b.size(), wr_q_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_raster();
        test_start_ignored();
        test_degenerate();
        test_level_ignored();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog got=stalled exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "simulation time limit");
    end

endmodule
